// File: rtl/clock_set_ctrl.sv
// Settable HH:MM:SS clock with debounced five-button editing.
// Time advances once per CLK_HZ cycles in RUN; SET states edit one field at a time.
module clock_set_ctrl #(
   parameter int unsigned CLK_HZ          = 50000000,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned BLINK_DIV       = 12500000
) (
   input  logic       clk100,
   input  logic       rst_n,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnC,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       set_mode,
   output logic [1:0] field_sel,
   output logic       blink,
   output logic       sec_tick
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned BW = $clog2(BLINK_DIV + 1);
   localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DB_TOP    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } state_t;

   state_t               state;
   logic [4:0]           btn_raw;
   logic [4:0]           sync1;
   logic [4:0]           sync2;
   logic [4:0]           db;
   logic [4:0]           press;
   logic [4:0][DW-1:0]   db_cnt;
   logic [PW-1:0]        presc;
   logic [BW-1:0]        blink_cnt;

   logic p_u, p_d, p_l, p_r, p_c;
   logic ud_ok, lr_ok, any_edit, tick;
   logic [5:0] sec_inc, sec_dec, min_inc, min_dec;
   logic [4:0] hr_inc, hr_dec;

   assign btn_raw = {btnC, btnR, btnL, btnD, btnU};

   // Debounced level follows sync2 only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         press  <= '0;
         db_cnt <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int unsigned i = 0; i < 5; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] != db[i]) begin
               if (db_cnt[i] == DB_TOP) begin
                  db[i]     <= sync2[i];
                  db_cnt[i] <= '0;
                  press[i]  <= sync2[i];
               end else begin
                  db_cnt[i] <= db_cnt[i] + DW'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign p_u = press[0];
   assign p_d = press[1];
   assign p_l = press[2];
   assign p_r = press[3];
   assign p_c = press[4];

   assign ud_ok    = p_u ^ p_d;
   assign lr_ok    = p_l ^ p_r;
   assign any_edit = p_u | p_d | p_l | p_r;
   assign tick     = (state == RUN) && (presc == PRESC_TOP);

   assign sec_inc = (seconds == 6'd59) ? 6'd0  : seconds + 6'd1;
   assign sec_dec = (seconds == 6'd0)  ? 6'd59 : seconds - 6'd1;
   assign min_inc = (minutes == 6'd59) ? 6'd0  : minutes + 6'd1;
   assign min_dec = (minutes == 6'd0)  ? 6'd59 : minutes - 6'd1;
   assign hr_inc  = (hours == 5'd23)   ? 5'd0  : hours + 5'd1;
   assign hr_dec  = (hours == 5'd0)    ? 5'd23 : hours - 5'd1;

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         hours     <= '0;
         minutes   <= '0;
         seconds   <= '0;
         presc     <= '0;
         blink     <= 1'b0;
         blink_cnt <= '0;
         sec_tick  <= 1'b0;
         set_mode  <= 1'b0;
         field_sel <= 2'd0;
      end else begin
         sec_tick <= 1'b0;
         if (state == RUN) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
            // A tick coinciding with pC is still applied before entering SET_HR.
            if (tick) begin
               presc    <= '0;
               sec_tick <= 1'b1;
               seconds  <= sec_inc;
               if (seconds == 6'd59) begin
                  minutes <= min_inc;
                  if (minutes == 6'd59) hours <= hr_inc;
               end
            end else begin
               presc <= presc + PW'(1);
            end
            if (p_c) begin
               state     <= SET_HR;
               field_sel <= 2'd1;
               set_mode  <= 1'b1;
               blink     <= 1'b1;
            end
         end else if (p_c) begin
            state     <= RUN;
            field_sel <= 2'd0;
            set_mode  <= 1'b0;
            presc     <= '0;
            blink     <= 1'b0;
            blink_cnt <= '0;
         end else begin
            // U/D acts on the field selected before any simultaneous L/R move.
            if (ud_ok) begin
               case (state)
                  SET_HR:  hours   <= p_u ? hr_inc  : hr_dec;
                  SET_MIN: minutes <= p_u ? min_inc : min_dec;
                  SET_SEC: seconds <= p_u ? sec_inc : sec_dec;
                  default: ;
               endcase
            end
            if (lr_ok) begin
               case (state)
                  SET_HR: begin
                     state     <= p_r ? SET_MIN : SET_SEC;
                     field_sel <= p_r ? 2'd2 : 2'd3;
                  end
                  SET_MIN: begin
                     state     <= p_r ? SET_SEC : SET_HR;
                     field_sel <= p_r ? 2'd3 : 2'd1;
                  end
                  SET_SEC: begin
                     state     <= p_r ? SET_HR : SET_MIN;
                     field_sel <= p_r ? 2'd1 : 2'd2;
                  end
                  default: ;
               endcase
            end
            if (any_edit) begin
               blink     <= 1'b1;
               blink_cnt <= '0;
            end else if (blink_cnt == BLINK_TOP) begin
               blink     <= ~blink;
               blink_cnt <= '0;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected output snapshots,
// a monitor pops one whenever the visible time/mode outputs change or sec_tick fires.
module tb_clock_set_ctrl;

   localparam int unsigned CLK_HZ = 10;
   localparam int unsigned DEB    = 4;
   localparam int unsigned BLK    = 3;

   localparam logic [4:0] B_U = 5'b00001;
   localparam logic [4:0] B_D = 5'b00010;
   localparam logic [4:0] B_L = 5'b00100;
   localparam logic [4:0] B_R = 5'b01000;
   localparam logic [4:0] B_C = 5'b10000;

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic [1:0] f;
      logic       sm;
      logic       tk;
   } obs_t;

   logic       clk100 = 1'b0;
   logic       rst_n;
   logic [4:0] btns;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       set_mode;
   logic [1:0] field_sel;
   logic       blink;
   logic       sec_tick;

   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   obs_t exp_q[$];

   always #5 clk100 = ~clk100;

   clock_set_ctrl #(
      .CLK_HZ(CLK_HZ),
      .DEBOUNCE_CYCLES(DEB),
      .BLINK_DIV(BLK)
   ) dut (
      .clk100(clk100),
      .rst_n(rst_n),
      .btnU(btns[0]),
      .btnD(btns[1]),
      .btnL(btns[2]),
      .btnR(btns[3]),
      .btnC(btns[4]),
      .hours(hours),
      .minutes(minutes),
      .seconds(seconds),
      .set_mode(set_mode),
      .field_sel(field_sel),
      .blink(blink),
      .sec_tick(sec_tick)
   );

   initial begin : monitor
      obs_t        cur;
      obs_t        want;
      logic [19:0] cur_st;
      logic [19:0] prev_st;
      prev_st = '0;
      forever begin
         @(negedge clk100);
         cur    = {hours, minutes, seconds, field_sel, set_mode, sec_tick};
         cur_st = cur[20:1];
         if (mon_en && ((cur_st != prev_st) || sec_tick)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output @%0t: got %0d:%0d:%0d f=%0d set=%0d tick=%0d, required none",
                        $time, cur.h, cur.m, cur.s, cur.f, cur.sm, cur.tk);
            end else begin
               want = exp_q.pop_front();
               if (cur !== want) begin
                  errors++;
                  $display("FAIL scoreboard @%0t: got %0d:%0d:%0d f=%0d set=%0d tick=%0d, required %0d:%0d:%0d f=%0d set=%0d tick=%0d",
                           $time, cur.h, cur.m, cur.s, cur.f, cur.sm, cur.tk,
                           want.h, want.m, want.s, want.f, want.sm, want.tk);
               end
            end
         end
         prev_st = cur_st;
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   task automatic push(input int h, input int m, input int s, input int f, input int sm, input int tk);
      obs_t o;
      o.h  = 5'(h);
      o.m  = 6'(m);
      o.s  = 6'(s);
      o.f  = 2'(f);
      o.sm = 1'(sm);
      o.tk = 1'(tk);
      exp_q.push_back(o);
   endtask

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic press(input logic [4:0] mask, input int hold);
      @(negedge clk100);
      btns = mask;
      repeat (hold) @(negedge clk100);
      btns = '0;
      repeat (10) @(negedge clk100);
   endtask

   task automatic wait_tick(input string name, input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk100);
         n++;
      end while (!sec_tick && n < limit);
      if (!sec_tick) begin
         checks++;
         errors++;
         $display("FAIL %s: got no sec_tick, required one within %0d cycles", name, limit);
      end
   endtask

   initial begin : stimulus
      int n;
      rst_n = 1'b0;
      btns  = '0;
      repeat (3) @(negedge clk100);
      check("reset_time", {hours, minutes, seconds}, 0);
      check("reset_mode", {set_mode, field_sel}, 0);
      check("reset_strobes", {blink, sec_tick}, 0);

      // Free run: one tick every 10 cycles, minute carry after 600.
      for (int unsigned i = 1; i <= 60; i++) push(0, i / 60, i % 60, 0, 0, 1);
      mon_en = 1'b1;
      rst_n  = 1'b1;
      wait_tick("first_tick", 20, n);
      check("first_tick_latency", n, 10);
      repeat (590) @(negedge clk100);
      check("minute_carry_min", minutes, 1);
      check("minute_carry_sec", seconds, 0);

      push(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk100);
      rst_n = 1'b1;

      // Enter SET, hours 0 -> 23 by decrement, move to minutes.
      push(0, 0, 0, 1, 1, 0);
      press(B_C, 8);
      push(23, 0, 0, 1, 1, 0);
      press(B_D, 8);
      push(23, 0, 0, 2, 1, 0);
      press(B_R, 8);

      // Long hold gives one increment; blink forced on then toggles every 3 cycles.
      push(23, 1, 0, 2, 1, 0);
      @(negedge clk100);
      btns = B_U;
      n = 0;
      do begin
         @(negedge clk100);
         n++;
      end while (minutes != 6'd1 && n < 20);
      check("hold_incr", minutes, 1);
      check("blink_forced", blink, 1);
      repeat (3) @(negedge clk100);
      check("blink_off", blink, 0);
      repeat (3) @(negedge clk100);
      check("blink_on", blink, 1);
      repeat (90) @(negedge clk100);
      btns = '0;
      repeat (10) @(negedge clk100);

      for (int unsigned i = 2; i <= 60; i++) begin
         push(23, i % 60, 0, 2, 1, 0);
         press(B_U, 8);
      end
      check("edit_hours", hours, 23);
      check("edit_field", field_sel, 2);
      check("edit_min_wrap", minutes, 0);
      check("edit_sec_kept", seconds, 0);

      // Glitches shorter than the debounce window are ignored.
      repeat (5) begin
         @(negedge clk100);
         btns = B_U;
         repeat (2) @(negedge clk100);
         btns = '0;
         @(negedge clk100);
      end
      repeat (10) @(negedge clk100);
      check("glitch_ignored", minutes, 0);

      press(B_U | B_D, 8);
      check("ud_cancel", minutes, 0);

      // Preload 23:59:59 exercising combined and cancelled moves.
      push(23, 59, 0, 2, 1, 0);
      press(B_D, 8);
      push(23, 59, 0, 3, 1, 0);
      press(B_R, 8);
      push(23, 59, 59, 2, 1, 0);
      press(B_D | B_L, 8);
      push(23, 59, 59, 3, 1, 0);
      press(B_R, 8);
      press(B_L | B_R, 8);
      check("lr_cancel", field_sel, 3);
      push(23, 59, 59, 1, 1, 0);
      press(B_R, 8);
      push(23, 59, 59, 3, 1, 0);
      press(B_L, 8);

      // pC with pU: mode change only; then first tick exactly 10 cycles after exit.
      push(23, 59, 59, 0, 0, 0);
      push(0, 0, 0, 0, 0, 1);
      @(negedge clk100);
      btns = B_C | B_U;
      n = 0;
      do begin
         @(negedge clk100);
         n++;
      end while (set_mode && n < 20);
      check("exit_to_run", set_mode, 0);
      wait_tick("exit_tick", 30, n);
      check("exit_tick_latency", n, 10);
      btns = '0;

      // Time pC so it lands on the same edge as a tick.
      push(0, 0, 1, 0, 0, 1);
      wait_tick("run_tick", 15, n);
      repeat (3) @(negedge clk100);
      push(0, 0, 2, 1, 1, 1);
      btns = B_C;
      repeat (8) @(negedge clk100);
      btns = '0;
      repeat (10) @(negedge clk100);

      push(0, 0, 2, 2, 1, 0);
      press(B_R, 8);
      push(0, 1, 2, 2, 1, 0);
      press(B_U, 8);

      // Asynchronous reset mid-edit, between clock edges.
      @(posedge clk100);
      #2;
      push(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check("async_rst_time", {hours, minutes, seconds}, 0);
      check("async_rst_mode", {set_mode, field_sel}, 0);
      check("async_rst_strobes", {blink, sec_tick}, 0);
      @(negedge clk100);
      @(negedge clk100);
      rst_n = 1'b1;

      // Reset during debounce discards the press.
      @(negedge clk100);
      btns = B_C;
      repeat (3) @(negedge clk100);
      rst_n = 1'b0;
      btns  = '0;
      repeat (2) @(negedge clk100);
      push(0, 0, 1, 0, 0, 1);
      push(0, 0, 2, 0, 0, 1);
      rst_n = 1'b1;
      repeat (25) @(negedge clk100);
      check("pending_press_dropped", set_mode, 0);

      // Button held through reset release yields exactly one press.
      push(0, 0, 0, 0, 0, 0);
      btns  = B_C;
      rst_n = 1'b0;
      repeat (3) @(negedge clk100);
      push(0, 0, 0, 1, 1, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk100);
      btns = '0;
      repeat (10) @(negedge clk100);
      check("held_through_reset", field_sel, 1);

      repeat (5) @(negedge clk100);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, the clk100 frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of stable cycles required to accept a button level.
REQ-003 SHALL have parameter BLINK_DIV, default 12500000, the number of cycles per blink half-period.
REQ-004 clk100  in  1  single system clock; all state is clocked on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 btnU, btnD, btnL, btnR, btnC  in  1 each  raw asynchronous push-button levels; active-high.
REQ-007 hours  out  5  current hours, binary, 0-23.
REQ-008 minutes  out  6  current minutes, binary, 0-59.
REQ-009 seconds  out  6  current seconds, binary, 0-59.
REQ-010 set_mode  out  1  high when the block is in any SET state.
REQ-011 field_sel  out  2  field being edited: 0=none (RUN), 1=hours, 2=minutes, 3=seconds.
REQ-012 blink  out  1  display blank strobe for the selected field; 0 in RUN.
REQ-013 sec_tick  out  1  one-cycle pulse each time seconds advances in RUN.

Function
REQ-014 Each button SHALL pass through a 2-FF synchronizer, then a debouncer; the debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 A debounced 0->1 transition SHALL produce a one-cycle press pulse (pU/pD/pL/pR/pC); release produces nothing; holding produces one pulse only.
REQ-016 Worst-case press-to-pulse latency SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-017 A prescaler SHALL count 0..CLK_HZ-1 in RUN and generate the internal tick when it wraps to 0.
REQ-018 On tick in RUN: seconds+1; 59->0 with carry to minutes; minutes 59->0 with carry to hours; hours 23->0; sec_tick pulses in the same cycle the new seconds value appears.
REQ-019 The FSM SHALL have states RUN, SET_HR, SET_MIN, SET_SEC, with field_sel = 0,1,2,3 respectively.
REQ-020 RUN + pC -> SET_HR; prescaler frozen; time frozen.
REQ-021 SET_* + pC -> RUN; the prescaler clears to 0 so the first tick after exit arrives exactly CLK_HZ cycles later.
REQ-022 In SET, pR SHALL advance HR->MIN->SEC->HR and pL SHALL reverse SEC->MIN->HR->SEC.
REQ-023 In SET, pU/pD SHALL increment/decrement only the selected field modulo its range (hours 24, minutes/seconds 60), with no carry or borrow into other fields.
REQ-024 In RUN, pU, pD, pL, and pR SHALL be ignored.
REQ-025 Simultaneous press pulses: pC has priority and all others are discarded that cycle; pU+pD together are discarded; pL+pR together are discarded; otherwise one U/D and one L/R pulse in the same cycle apply U/D to the old field and then move the field.
REQ-026 A tick coincident with pC in RUN SHALL be applied first, then the FSM enters SET_HR with the advanced time.
REQ-027 blink SHALL toggle every BLINK_DIV cycles while in SET; its counter restarts and blink is forced to 1 on any pU/pD/pL/pR, so the edited field is visible immediately.
REQ-028 set_mode SHALL be registered and equal to (state != RUN).

Reset
REQ-029 rst_n low SHALL asynchronously force: state=RUN, hours=minutes=seconds=0, prescaler=0, blink=0, sec_tick=0, debounced levels=0, synchronizers=0, debounce and blink counters=0.
REQ-030 A button held through reset deassertion SHALL produce exactly one press pulse once it has been debounced.
REQ-031 Reset asserted mid-debounce or mid-edit SHALL discard the pending press and the edits; operation resumes in RUN from 00:00:00.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4, BLINK_DIV=3)
REQ-032 Release reset and wait 10 cycles -> sec_tick pulse with seconds=1; after 600 cycles -> minutes=1, seconds=0.
REQ-033 Preload 23:59:59 via SET, then return to RUN -> after exactly 10 cycles the time is 00:00:00 and sec_tick pulses once.
REQ-034 Press btnC (hold 8 cycles), pD x1 on hours=0, then btnR, then pU x60 on minutes -> hours=23, field_sel=2, minutes=0 (wrap), seconds unchanged.
REQ-035 btnU toggling with 2-cycle glitches -> no pulse; btnU held 100 cycles -> exactly one increment.
REQ-036 btnU and btnD pulses in the same cycle -> no change; pC with pU in the same cycle -> mode change only, no field change.
REQ-037 Assert rst_n low in SET_MIN at 12:34:56 -> all outputs zero and state RUN immediately, without waiting for a clock edge.
